// File: rtl/spi_slave.sv
// 16-bit SPI responder: oversamples SCLK/SS_n/MOSI in the clk domain and hands received words to the core.
// Optional macro SPI_SLAVE_FRM_ERR_EN adds a frm_err pulse output for discarded frames.
module spi_slave #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCLK,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             wrt,
  output logic [WIDTH-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_rdy
`ifdef SPI_SLAVE_FRM_ERR_EN
  ,
  output logic             frm_err
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sclk_sync_q;
  logic [2:0]       ss_sync_q;
  logic [1:0]       mosi_sync_q;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] tx_shft_q, tx_shft_d;
  logic [WIDTH-1:0] rx_shft_q, rx_shft_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             first_rise_q, first_rise_d;
  logic [WIDTH-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             frm_err_d;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_sync;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign mosi_sync = mosi_sync_q[1];

  // Synchronizers preset to idle pin levels so reset release creates no false edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q  <= '1;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      state_q      <= IDLE;
      tx_buf_q     <= '0;
      tx_shft_q    <= '0;
      rx_shft_q    <= '0;
      bit_cnt_q    <= '0;
      first_rise_q <= 1'b0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], SCLK};
      ss_sync_q    <= {ss_sync_q[1:0], SS_n};
      mosi_sync_q  <= {mosi_sync_q[0], MOSI};
      state_q      <= state_d;
      tx_buf_q     <= tx_buf_d;
      tx_shft_q    <= tx_shft_d;
      rx_shft_q    <= rx_shft_d;
      bit_cnt_q    <= bit_cnt_d;
      first_rise_q <= first_rise_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_buf_d     = wrt ? tx_data : tx_buf_q;
    tx_shft_d    = tx_shft_q;
    rx_shft_d    = rx_shft_q;
    bit_cnt_d    = bit_cnt_q;
    first_rise_d = first_rise_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = clr_rdy ? 1'b0 : cmd_rdy_q;
    frm_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_shft_d    = tx_buf_q;
          bit_cnt_d    = '0;
          first_rise_d = 1'b0;
          cmd_rdy_d    = 1'b0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        // SS_n events take priority; a coincident SCLK edge is dropped.
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CW'(WIDTH)) begin
            cmd_d     = rx_shft_q;
            cmd_rdy_d = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_shft_d    = {rx_shft_q[WIDTH-2:0], mosi_sync};
          first_rise_d = 1'b1;
          if (bit_cnt_q != CW'(WIDTH + 1)) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall && first_rise_q) begin
          tx_shft_d = {tx_shft_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO    = tx_shft_q[WIDTH-1];
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

`ifdef SPI_SLAVE_FRM_ERR_EN
  logic frm_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= frm_err_d;
    end
  end

  assign frm_err = frm_err_q;
`else
  logic unused_frm_err;
  assign unused_frm_err = frm_err_d;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: event-scheduled reference model plus directed and random SPI frames.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n, SCLK, SS_n, MOSI, MISO, wrt, cmd_rdy, clr_rdy;
  logic [15:0] tx_data, cmd;
`ifdef SPI_SLAVE_FRM_ERR_EN
  logic        frm_err;
`endif

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SCLK    (SCLK),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .cmd_rdy (cmd_rdy),
    .clr_rdy (clr_rdy)
`ifdef SPI_SLAVE_FRM_ERR_EN
    ,
    .frm_err (frm_err)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Reference model: pin events take effect 3 clk edges after the bench drives them.
  typedef struct {
    int          due;
    bit          is_fall;
    bit          valid;
    logic [15:0] data;
  } ev_t;

  ev_t         evq[$];
  logic [15:0] m_cmd   = '0;
  logic [15:0] m_txbuf = '0;
  logic        m_rdy   = 1'b0;
  logic        m_ferr  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    ev_t e;
    cyc++;
    if (!rst_n) begin
      m_cmd   = '0;
      m_rdy   = 1'b0;
      m_txbuf = '0;
      m_ferr  = 1'b0;
      evq.delete();
    end else begin
      m_ferr = 1'b0;
      if (wrt) m_txbuf = tx_data;
      if (clr_rdy) m_rdy = 1'b0;
      while (evq.size() > 0 && evq[0].due == cyc) begin
        e = evq.pop_front();
        if (e.is_fall) m_rdy = 1'b0;
        else if (e.valid) begin
          m_cmd = e.data;
          m_rdy = 1'b1;
        end else m_ferr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd", cmd, m_cmd);
      check("cmd_rdy", {15'b0, cmd_rdy}, {15'b0, m_rdy});
`ifdef SPI_SLAVE_FRM_ERR_EN
      check("frm_err", {15'b0, frm_err}, {15'b0, m_ferr});
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_fall();
    ev_t e;
    SS_n = 1'b0;
    e.due = cyc + 3; e.is_fall = 1'b1; e.valid = 1'b0; e.data = '0;
    evq.push_back(e);
  endtask

  task automatic ss_rise(input bit valid, input logic [15:0] d);
    ev_t e;
    SS_n = 1'b1;
    e.due = cyc + 3; e.is_fall = 1'b0; e.valid = valid; e.data = d;
    evq.push_back(e);
  endtask

  task automatic pulse_wrt(input logic [15:0] v);
    tx_data = v;
    wrt = 1'b1;
    tick(1);
    wrt = 1'b0;
  endtask

  // One master frame at clk/32; returns on the cycle SS_n is raised.
  task automatic frame(input logic [15:0] mosi_w, input int nbits, input bit idle_hi,
                       input int wrt_bit, input logic [15:0] wrt_val, input int rst_bit,
                       output logic [15:0] miso_w, output logic [15:0] exp_tx);
    logic b;
    SCLK = idle_hi;
    tick(20);
    exp_tx = m_txbuf;
    ss_fall();
    tick(16);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        tick(20);
        return;
      end
      b = (i < 16) ? mosi_w[15-i] : 1'b1;
      if (idle_hi) begin
        SCLK = 1'b0;
        MOSI = b;
        tick(16);
        SCLK = 1'b1;
        miso_w = {miso_w[14:0], MISO};
        tick(16);
      end else begin
        MOSI = b;
        tick(16);
        SCLK = 1'b1;
        miso_w = {miso_w[14:0], MISO};
        tick(16);
        SCLK = 1'b0;
      end
      if (i == wrt_bit) pulse_wrt(wrt_val);
    end
    tick(16);
    ss_rise(nbits == 16, mosi_w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] mw, et, w;
    int          nb, sel;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; clr_rdy = 1'b0; tx_data = '0;
    tick(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_miso", {15'b0, MISO}, 16'h0);
    check("reset_cmd", cmd, 16'h0);
    check("reset_rdy", {15'b0, cmd_rdy}, 16'h0);

    // Basic frame, latency and hold-until-clear.
    pulse_wrt(16'hA5C3);
    frame(16'h1234, 16, 1'b0, -1, 16'h0, -1, mw, et);
    tick(2);
    check("lat_rdy_early", {15'b0, cmd_rdy}, 16'h0);
    tick(1);
    check("lat_rdy", {15'b0, cmd_rdy}, 16'h1);
    check("t1_cmd", cmd, 16'h1234);
    check("t1_miso", mw, 16'hA5C3);
    check("t1_model_tx", et, 16'hA5C3);
    tick(10);
    check("t1_hold", {15'b0, cmd_rdy}, 16'h1);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    check("t1_clr", {15'b0, cmd_rdy}, 16'h0);

    // Idle-high SCLK: leading fall must not consume the MSB.
    pulse_wrt(16'h8001);
    frame(16'h3C3C, 16, 1'b1, -1, 16'h0, -1, mw, et);
    tick(4);
    check("t2_miso", mw, 16'h8001);

    // Mid-frame wrt only affects the next frame; set beats clr in the same cycle.
    pulse_wrt(16'h0F0F);
    frame(16'h3C3C, 16, 1'b1, 7, 16'hFFFF, -1, mw, et);
    tick(4);
    check("t3_miso_cur", mw, 16'h0F0F);
    frame(16'hC3C3, 16, 1'b1, -1, 16'h0, -1, mw, et);
    tick(2);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    check("t3_set_wins", {15'b0, cmd_rdy}, 16'h1);
    check("t3_miso_next", mw, 16'hFFFF);

    // Short frame is discarded.
    frame(16'hAAAA, 9, 1'b1, -1, 16'h0, -1, mw, et);
    tick(2);
`ifdef SPI_SLAVE_FRM_ERR_EN
    check("t4_ferr_pre", {15'b0, frm_err}, 16'h0);
`endif
    tick(1);
`ifdef SPI_SLAVE_FRM_ERR_EN
    check("t4_ferr", {15'b0, frm_err}, 16'h1);
`endif
    tick(1);
`ifdef SPI_SLAVE_FRM_ERR_EN
    check("t4_ferr_post", {15'b0, frm_err}, 16'h0);
`endif
    check("t4_cmd", cmd, 16'hC3C3);
    check("t4_rdy", {15'b0, cmd_rdy}, 16'h0);

    // Over-long frame discarded, then a clean frame.
    frame(16'h1111, 17, 1'b0, -1, 16'h0, -1, mw, et);
    tick(4);
    check("t5_cmd_kept", cmd, 16'hC3C3);
    frame(16'hBEEF, 16, 1'b1, -1, 16'h0, -1, mw, et);
    tick(4);
    check("t5_cmd", cmd, 16'hBEEF);
    check("t5_rdy", {15'b0, cmd_rdy}, 16'h1);

    // Reset in the middle of a frame.
    frame(16'h7777, 16, 1'b1, -1, 16'h0, 7, mw, et);
    check("t6_miso", {15'b0, MISO}, 16'h0);
    check("t6_cmd", cmd, 16'h0);
    check("t6_rdy", {15'b0, cmd_rdy}, 16'h0);
    frame(16'h5555, 16, 1'b0, -1, 16'h0, -1, mw, et);
    tick(4);
    check("t6_cmd_after", cmd, 16'h5555);
    check("t6_miso_after", mw, 16'h0000);

    // Randomized frames against the model.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) pulse_wrt(16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
      end
      tick($urandom_range(0, 30));
      sel = $urandom_range(0, 5);
      nb  = (sel == 3) ? 9 : (sel == 4) ? 15 : (sel == 5) ? 17 : 16;
      w   = 16'($urandom);
      frame(w, nb, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : -1,
            16'($urandom), -1, mw, et);
      if (nb == 16) check("rnd_miso", mw, et);
      tick(6);
    end

    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
